mc_control: RTL and testbench
=============================

# mc_control

Multicycle main control unit for the one-memory MIPS datapath. A Moore state machine sequences each instruction through fetch, decode, execute, memory and writeback. Each cycle it drives the datapath mux selects, the register, IR, PC and memory write enables, and the 2-bit `aluop` consumed by the ALU decoder. It stalls on a memory-ready handshake and pulses `retire` once per completed instruction.

## Interface
Parameters:
- none; all encodings are fixed in `mc_pkg`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 6: opcode, IR[31:26]; valid from DECODE onward.
- `zero` in 1: ALU zero flag, same cycle.
- `mem_ready` in 1: memory completes the current access this cycle.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `irwrite` out 1: IR load enable.
- `memwrite` out 1: memory write strobe.
- `regwrite` out 1: register file write enable.
- `regdst` out 1: destination select; 0 = rt, 1 = rd.
- `memtoreg` out 1: writeback select; 0 = ALUOut, 1 = MDR.
- `alusrca` out 1: ALU A select; 0 = PC, 1 = A register.
- `alusrcb` out 2: ALU B select; 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `pcsrc` out 2: PC source; 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `aluop` out 2: 00 = add, 01 = subtract, 10 = use funct.
- `pcen` out 1: PC load enable, pcwrite | (branch & zero).
- `retire` out 1: one-cycle pulse in the last cycle of an instruction.
- `illegal` out 1: one-cycle pulse in DECODE on an unsupported opcode.

## Operation
States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.

Unlisted outputs are 0 in every state.
- **FETCH**
  - Drives alusrcb=01, aluop=00, pcsrc=00, iord=0.
  - irwrite and pcen assert only when mem_ready=1.
  - Stays in FETCH while mem_ready=0; otherwise goes to DECODE.
- **DECODE**
  - Drives alusrcb=11, aluop=00.
  - Next state by op:
    - 100011 lw or 101011 sw -> MEMADR
    - 000000 R-type -> EXEC
    - 000100 beq -> BRANCH
    - 001000 addi -> ADDIEX
    - 000010 j -> JUMP
    - any other op -> FETCH, with illegal=1 and retire=0.
- **MEMADR**
  - Drives alusrca=1, alusrcb=10, aluop=00.
  - lw -> MEMRD; sw -> MEMWR.
  - Uses op held in IR, which is stable because irwrite=0.
- **MEMRD**: drives iord=1; waits for mem_ready; then -> MEMWB.
- **MEMWB**: regwrite=1, memtoreg=1, regdst=0, retire=1; -> FETCH.
- **MEMWR**
  - Drives iord=1, memwrite=1.
  - Holds memwrite until mem_ready, then retire=1 -> FETCH.
- **EXEC**: alusrca=1, alusrcb=00, aluop=10; -> ALUWB.
- **ALUWB**: regwrite=1, regdst=1, memtoreg=0, retire=1; -> FETCH.
- **BRANCH**
  - Drives alusrca=1, alusrcb=00, aluop=01, pcsrc=01.
  - pcen=zero, retire=1; -> FETCH.
- **ADDIEX**: alusrca=1, alusrcb=10, aluop=00; -> ADDIWB.
- **ADDIWB**: regwrite=1, regdst=0, memtoreg=0, retire=1; -> FETCH.
- **JUMP**: pcsrc=10, pcen=1, retire=1; -> FETCH.

## Timing
- **Reset**
  - rst_n low forces state=FETCH immediately.
  - While rst_n is low, all enables and pulses (irwrite, pcen, memwrite, regwrite, retire, illegal) are forced 0.
  - All selects read 0, except alusrcb=01 (FETCH value).
- **Reset release**: the first rising edge with rst_n=1 evaluates FETCH normally.
- **Reset mid-instruction**: abandons the instruction with no partial write after the reset edge.
- **Outputs**: Moore, decoded from the state register. Only pcen (from zero) and the FETCH/MEMWR completion qualifiers (from mem_ready) are combinational.
- **Cycle counts with mem_ready tied 1**:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Each extra mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- **retire** is high exactly once per legal instruction.
- **State encoding**: 4 bits. Unused encodings recover to FETCH on the next edge with all enables 0.

## Structure
- `mc_pkg` holds:
  - the state enum;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - aluop constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10, shared with the ALU decoder;
  - the alusrcb and pcsrc select constants.
- One combinational sub-module `mc_outdec` maps (state, mem_ready) to the control word.
- `mc_control` holds the state register, the next-state logic and the pcen/reset gating.

## Test plan
- **lw**
  - Stimulus: rst_n low then high, op=100011, mem_ready=1.
  - Required: states FETCH, DECODE, MEMADR, MEMRD, MEMWB.
  - Required: regwrite=1 and memtoreg=1 only in cycle 5; retire once.
- **sw with memory stall**
  - Stimulus: op=101011; mem_ready=0 for 2 cycles in MEMWR, then 1.
  - Required: memwrite high for 3 cycles; retire coincides with the mem_ready=1 cycle; 6 cycles total.
- **R-type then addi, back-to-back**
  - Required: aluop=10 in EXEC; regdst=1 in ALUWB.
  - Required: aluop=00 with alusrcb=10 in ADDIEX; regdst=0 in ADDIWB.
- **beq**
  - Stimulus: zero=1 in one pass, zero=0 in another.
  - Required: pcen=1 with pcsrc=01 when zero=1; pcen=0 when zero=0; aluop=01 in both.
- **Illegal opcode**
  - Stimulus: op=111111.
  - Required: illegal=1 for one cycle in DECODE, retire=0, next state FETCH.
- **Reset mid-operation and fetch stall**
  - Stimulus: rst_n pulled low during MEMWR; separately, mem_ready=0 for 3 cycles in FETCH.
  - Required: memwrite drops asynchronously and state=FETCH.
  - Required: irwrite=0 and pcen=0 until mem_ready=1.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle MIPS main control unit.
// Holds the FSM state enum, opcode constants, the aluop code shared with the
// ALU decoder, the alusrcb/pcsrc select codes and the internal control word.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Raw per-state control word; pcwrite/branch are combined with zero in the
  // top to form pcen.
  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       pcwrite;
    logic       branch;
    logic       retire;
  } ctl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// mc_outdec: Moore output decoder for mc_control.
// Ports:
//   state     in  current FSM state
//   mem_ready in  memory completes the current access this cycle
//   ctl       out raw control word (pcwrite/branch not yet combined with zero)
// Only the FETCH and MEMWR completion qualifiers look at mem_ready; every
// other field depends on the state alone. Unused encodings decode to all 0.
module mc_outdec
  import mc_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctl_t   ctl
);

  always_comb begin
    ctl = '0;
    case (state)
      S_FETCH: begin
        ctl.alusrcb = SRCB_FOUR;
        ctl.aluop   = ALUOP_ADD;
        ctl.pcsrc   = PCSRC_ALU;
        ctl.irwrite = mem_ready;
        ctl.pcwrite = mem_ready;
      end
      S_DECODE: begin
        ctl.alusrcb = SRCB_IMMSH;
        ctl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_IMM;
        ctl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: ctl.iord = 1'b1;
      S_MEMWB: begin
        ctl.regwrite = 1'b1;
        ctl.memtoreg = 1'b1;
        ctl.retire   = 1'b1;
      end
      S_MEMWR: begin
        // memwrite is held for the whole stall; retire marks the completing cycle
        ctl.iord     = 1'b1;
        ctl.memwrite = 1'b1;
        ctl.retire   = mem_ready;
      end
      S_EXEC: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_B;
        ctl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctl.regwrite = 1'b1;
        ctl.regdst   = 1'b1;
        ctl.retire   = 1'b1;
      end
      S_BRANCH: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_B;
        ctl.aluop   = ALUOP_SUB;
        ctl.pcsrc   = PCSRC_ALUOUT;
        ctl.branch  = 1'b1;
        ctl.retire  = 1'b1;
      end
      S_ADDIEX: begin
        ctl.alusrca = 1'b1;
        ctl.alusrcb = SRCB_IMM;
        ctl.aluop   = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctl.regwrite = 1'b1;
        ctl.retire   = 1'b1;
      end
      S_JUMP: begin
        ctl.pcsrc   = PCSRC_JUMP;
        ctl.pcwrite = 1'b1;
        ctl.retire  = 1'b1;
      end
      default: ctl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle main control unit for the one-memory MIPS datapath.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   op, zero          opcode from IR, ALU zero flag
//   mem_ready         memory completes the current access this cycle
//   iord .. aluop     datapath selects and write enables
//   pcen              pcwrite | (branch & zero)
//   retire            pulse in the last cycle of each legal instruction
//   illegal           pulse in DECODE on an unsupported opcode
//   state             current FSM state (debug/observability)
// Handshake: mem_ready is sampled in FETCH, MEMRD and MEMWR only; an access
// completes on the rising edge of any cycle where the state is waiting and
// mem_ready=1, and the FSM holds its state (and strobes) otherwise.
module mc_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       pcen,
  output logic       retire,
  output logic       illegal,
  output state_t     state
);

  state_t state_q;
  state_t state_d;
  ctl_t   ctl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      // IR is not reloaded after FETCH, so op still names lw or sw here
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctl       (ctl)
  );

  // Selects pass through; during reset the state is already FETCH so they
  // read the FETCH values. Enables and pulses are gated by rst_n so a FETCH
  // with mem_ready=1 cannot write while reset is held.
  assign iord     = ctl.iord;
  assign regdst   = ctl.regdst;
  assign memtoreg = ctl.memtoreg;
  assign alusrca  = ctl.alusrca;
  assign alusrcb  = ctl.alusrcb;
  assign pcsrc    = ctl.pcsrc;
  assign aluop    = ctl.aluop;
  assign irwrite  = rst_n & ctl.irwrite;
  assign memwrite = rst_n & ctl.memwrite;
  assign regwrite = rst_n & ctl.regwrite;
  assign pcen     = rst_n & (ctl.pcwrite | (ctl.branch & zero));
  assign retire   = rst_n & ctl.retire;
  assign illegal  = rst_n & (state_q == S_DECODE) & ~op_legal(op);
  assign state    = state_q;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: self-checking bench for mc_control.
// Directed table of per-cycle vectors, a randomized instruction stream whose
// expected cycles are produced by an instruction-level model, and a
// hand-written reset-during-store sequence.
module tb_mc_control;
  import mc_pkg::*;

  // field order: iord irwrite memwrite regwrite regdst memtoreg alusrca
  //              alusrcb pcsrc aluop pcen retire illegal
  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       pcen;
    logic       retire;
    logic       illegal;
  } out_t;

  typedef struct {
    logic [5:0] op;
    logic       zero;
    logic       mr;
    out_t       exp;
    state_t     st;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       pcen, retire, illegal;
  state_t     state;
  out_t       got;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  vec_t q[$];

  always #5 clk = ~clk;

  mc_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .aluop(aluop), .pcen(pcen), .retire(retire),
    .illegal(illegal), .state(state)
  );

  assign got = {iord, irwrite, memwrite, regwrite, regdst, memtoreg, alusrca,
                alusrcb, pcsrc, aluop, pcen, retire, illegal};

  // ---------------- checking ----------------
  task automatic check_out(input string tag, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s outputs got %b required %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input state_t exp);
    checks++;
    if (state !== exp) begin
      errors++;
      $display("FAIL %s state got %0d required %0d (t=%0t)", tag, state, exp, $time);
    end
  endtask

  // Called at posedge+1: drive, settle, compare, advance one clock.
  task automatic apply(input vec_t v, input string tag);
    op = v.op; zero = v.zero; mem_ready = v.mr;
    #2;
    check_out(tag, v.exp);
    check_state(tag, v.st);
    @(posedge clk); #1;
  endtask

  task automatic row(input logic [5:0] o, input logic z, input logic mr,
                     input logic [15:0] e, input state_t s);
    vec_t v;
    v.op = o; v.zero = z; v.mr = mr; v.exp = out_t'(e); v.st = s;
    tbl.push_back(v);
  endtask

  // ---------------- instruction-level reference model ----------------
  function automatic logic is_legal(input logic [5:0] o);
    return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  task automatic add(input logic [5:0] o, input logic z, input logic mr,
                     input out_t e, input state_t s);
    vec_t v;
    v.op = o; v.zero = z; v.mr = mr; v.exp = e; v.st = s;
    q.push_back(v);
  endtask

  // Appends every cycle of one instruction: fstall/mstall are the number of
  // mem_ready=0 cycles in FETCH and in the data access.
  task automatic model_instr(input logic [5:0] o, input logic z,
                             input int fstall, input int mstall);
    out_t e;
    logic [5:0] fop;
    for (int i = 0; i < fstall; i++) begin
      e = '0; e.alusrcb = 2'b01;
      fop = 6'($urandom_range(0, 63));
      add(fop, 1'($urandom_range(0, 1)), 1'b0, e, S_FETCH);
    end
    e = '0; e.alusrcb = 2'b01; e.irwrite = 1'b1; e.pcen = 1'b1;
    fop = 6'($urandom_range(0, 63));
    add(fop, 1'($urandom_range(0, 1)), 1'b1, e, S_FETCH);
    e = '0; e.alusrcb = 2'b11; e.illegal = !is_legal(o);
    add(o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, S_DECODE);
    if (o == 6'b100011 || o == 6'b101011) begin
      e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
      add(o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, S_MEMADR);
      for (int i = 0; i <= mstall; i++) begin
        e = '0; e.iord = 1'b1;
        if (o == 6'b101011) begin
          e.memwrite = 1'b1;
          e.retire = (i == mstall);
        end
        add(o, 1'($urandom_range(0, 1)), 1'(i == mstall), e,
            (o == 6'b100011) ? S_MEMRD : S_MEMWR);
      end
      if (o == 6'b100011) begin
        e = '0; e.regwrite = 1'b1; e.memtoreg = 1'b1; e.retire = 1'b1;
        add(o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, S_MEMWB);
      end
    end else if (o == 6'b000000) begin
      e = '0; e.alusrca = 1'b1; e.aluop = 2'b10;
      add(o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, S_EXEC);
      e = '0; e.regwrite = 1'b1; e.regdst = 1'b1; e.retire = 1'b1;
      add(o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, S_ALUWB);
    end else if (o == 6'b001000) begin
      e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
      add(o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, S_ADDIEX);
      e = '0; e.regwrite = 1'b1; e.retire = 1'b1;
      add(o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, S_ADDIWB);
    end else if (o == 6'b000100) begin
      e = '0; e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsrc = 2'b01;
      e.pcen = z; e.retire = 1'b1;
      add(o, z, 1'($urandom_range(0, 1)), e, S_BRANCH);
    end else if (o == 6'b000010) begin
      e = '0; e.pcsrc = 2'b10; e.pcen = 1'b1; e.retire = 1'b1;
      add(o, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e, S_JUMP);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    logic [5:0] legal_ops [6];
    logic [5:0] rop;
    legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};

    // directed table: op, zero, mem_ready, expected outputs, expected state
    // fetch stall (3 cycles) then lw
    row(6'h3f, 1, 0, 16'b0000000_01_00_00_000, S_FETCH);
    row(6'h3f, 1, 0, 16'b0000000_01_00_00_000, S_FETCH);
    row(6'h3f, 0, 0, 16'b0000000_01_00_00_000, S_FETCH);
    row(6'h3f, 0, 1, 16'b0100000_01_00_00_100, S_FETCH);
    row(6'b100011, 1, 1, 16'b0000000_11_00_00_000, S_DECODE);
    row(6'b100011, 1, 1, 16'b0000001_10_00_00_000, S_MEMADR);
    row(6'b100011, 1, 1, 16'b1000000_00_00_00_000, S_MEMRD);
    row(6'b100011, 1, 1, 16'b0001010_00_00_00_010, S_MEMWB);
    // sw with two stall cycles in MEMWR
    row(6'b100011, 0, 1, 16'b0100000_01_00_00_100, S_FETCH);
    row(6'b101011, 0, 1, 16'b0000000_11_00_00_000, S_DECODE);
    row(6'b101011, 0, 1, 16'b0000001_10_00_00_000, S_MEMADR);
    row(6'b101011, 1, 0, 16'b1010000_00_00_00_000, S_MEMWR);
    row(6'b101011, 1, 0, 16'b1010000_00_00_00_000, S_MEMWR);
    row(6'b101011, 0, 1, 16'b1010000_00_00_00_010, S_MEMWR);
    // R-type then addi back-to-back
    row(6'b101011, 0, 1, 16'b0100000_01_00_00_100, S_FETCH);
    row(6'b000000, 0, 1, 16'b0000000_11_00_00_000, S_DECODE);
    row(6'b000000, 1, 1, 16'b0000001_00_00_10_000, S_EXEC);
    row(6'b000000, 1, 1, 16'b0001100_00_00_00_010, S_ALUWB);
    row(6'b000000, 0, 1, 16'b0100000_01_00_00_100, S_FETCH);
    row(6'b001000, 0, 1, 16'b0000000_11_00_00_000, S_DECODE);
    row(6'b001000, 1, 1, 16'b0000001_10_00_00_000, S_ADDIEX);
    row(6'b001000, 1, 1, 16'b0001000_00_00_00_010, S_ADDIWB);
    // beq taken, beq not taken
    row(6'b001000, 0, 1, 16'b0100000_01_00_00_100, S_FETCH);
    row(6'b000100, 0, 1, 16'b0000000_11_00_00_000, S_DECODE);
    row(6'b000100, 1, 1, 16'b0000001_00_01_01_110, S_BRANCH);
    row(6'b000100, 0, 1, 16'b0100000_01_00_00_100, S_FETCH);
    row(6'b000100, 1, 1, 16'b0000000_11_00_00_000, S_DECODE);
    row(6'b000100, 0, 1, 16'b0000001_00_01_01_010, S_BRANCH);
    // j
    row(6'b000100, 0, 1, 16'b0100000_01_00_00_100, S_FETCH);
    row(6'b000010, 0, 1, 16'b0000000_11_00_00_000, S_DECODE);
    row(6'b000010, 0, 1, 16'b0000000_00_10_00_110, S_JUMP);
    // illegal opcode: pulse in DECODE, back to FETCH
    row(6'b000010, 0, 1, 16'b0100000_01_00_00_100, S_FETCH);
    row(6'b111111, 0, 1, 16'b0000000_11_00_00_001, S_DECODE);
    row(6'b111111, 0, 0, 16'b0000000_01_00_00_000, S_FETCH);

    // reset: selects at FETCH values, every enable held 0 even with mem_ready=1
    rst_n = 1'b0; op = 6'b0; zero = 1'b1; mem_ready = 1'b1;
    #2;
    check_out("reset_hold", out_t'(16'b0000000_01_00_00_000));
    check_state("reset_hold", S_FETCH);
    @(posedge clk); #1;
    check_out("reset_edge", out_t'(16'b0000000_01_00_00_000));
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("table%0d", i));

    // randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) < 6) rop = legal_ops[$urandom_range(0, 5)];
      else rop = 6'($urandom_range(0, 63));
      model_instr(rop, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    for (int i = 0; i < q.size(); i++)
      apply(q[i], $sformatf("rand%0d", i));
    q.delete();

    // reset pulled low while a store is stalled in MEMWR
    model_instr(6'b101011, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) apply(q[i], $sformatf("rst_sw%0d", i));
    q.delete();
    op = 6'b101011; mem_ready = 1'b0; zero = 1'b0;
    #2;
    checks++;
    if (memwrite !== 1'b1) begin
      errors++;
      $display("FAIL memwr_before_reset memwrite got %b required 1", memwrite);
    end
    rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    check_out("memwr_async_reset", out_t'(16'b0000000_01_00_00_000));
    check_state("memwr_async_reset", S_FETCH);
    @(posedge clk); #1;
    check_out("memwr_reset_edge", out_t'(16'b0000000_01_00_00_000));
    check_state("memwr_reset_edge", S_FETCH);
    rst_n = 1'b1;
    model_instr(6'b000010, 1'b0, 3, 0);
    for (int i = 0; i < q.size(); i++) apply(q[i], $sformatf("post_reset%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
